// File: rtl/lbus_if_param.sv
// Parametrised SASEBO 16-bit local-bus register interface to a block-cipher core.
// Optional feature macro LBUS_READBACK_EN: makes the KEY and DIN windows readable.
module lbus_if_param #(
    parameter int          KEY_W     = 128,
    parameter int          DIN_W     = 512,
    parameter int          DOUT_W    = 128,
    parameter int          TRIG_DLY  = 3,
    parameter logic [15:0] KEY_BASE  = 16'h0100,
    parameter logic [15:0] DIN_BASE  = 16'h0140,
    parameter logic [15:0] DOUT_BASE = 16'h0180,
    parameter logic [15:0] ID_CODE   = 16'h4702
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [15:0]       lbus_a,
    input  logic [15:0]       lbus_di,
    input  logic              lbus_wr,
    input  logic              lbus_rd,
    output logic [15:0]       lbus_do,
    output logic [KEY_W-1:0]  blk_kin,
    output logic [DIN_W-1:0]  blk_din,
    input  logic [DOUT_W-1:0] blk_dout,
    output logic              blk_krdy,
    output logic              blk_drdy,
    input  logic              blk_kvld,
    input  logic              blk_dvld,
    output logic              blk_encdec,
    output logic              blk_en,
    output logic              blk_rstn
);
    localparam int          KEY_N     = KEY_W / 16;
    localparam int          DIN_N     = DIN_W / 16;
    localparam int          DOUT_N    = DOUT_W / 16;
    localparam logic [15:0] KEY_SPAN  = 16'(2 * KEY_N);
    localparam logic [15:0] DIN_SPAN  = 16'(2 * DIN_N);
    localparam logic [15:0] DOUT_SPAN = 16'(2 * DOUT_N);
    localparam logic [15:0] A_CTRL    = 16'h0002;
    localparam logic [15:0] A_LAT     = 16'h0004;
    localparam logic [15:0] A_MODE    = 16'h000C;
    localparam logic [15:0] A_ID      = 16'hFFFC;

    typedef enum logic [1:0] {S_IDLE, S_WAIT_DRDY, S_RUN} state_t;

    state_t              state_q, state_d;
    logic [2:0]          wr_sync_q, wr_sync_d;
    logic [TRIG_DLY-1:0] dly_q, dly_d;
    logic                krdy_q, krdy_d, srst_q, srst_d, rst_act_q, rst_act_d;
    logic                kbusy_q, kbusy_d, done_q, done_d, ovr_q, ovr_d;
    logic [15:0]         lat_q, lat_d, do_q, do_d, rdata, status;
    logic [1:0]          mode_q, mode_d;
    logic [KEY_W-1:0]    key_q, key_d;
    logic [DIN_W-1:0]    din_q, din_d;
    logic [DOUT_W-1:0]   dout_q, dout_d;
    logic [15:0]         key_off, din_off, dout_off;
    logic                key_hit, din_hit, dout_hit;
    logic                trig_wr, ctrl_wr, start_req, dbusy;

    // Two sync stages, the third flop only remembers the previous level for edge detection.
    assign wr_sync_d = {wr_sync_q[1:0], lbus_wr};
    assign trig_wr   = wr_sync_q[1] & ~wr_sync_q[2];

    assign key_off  = lbus_a - KEY_BASE;
    assign din_off  = lbus_a - DIN_BASE;
    assign dout_off = lbus_a - DOUT_BASE;
    assign key_hit  = ~key_off[0]  && (key_off  < KEY_SPAN);
    assign din_hit  = ~din_off[0]  && (din_off  < DIN_SPAN);
    assign dout_hit = ~dout_off[0] && (dout_off < DOUT_SPAN);

    assign dbusy     = (state_q != S_IDLE);
    assign status    = {11'b0, ovr_q, done_q, rst_act_q, kbusy_q, dbusy};
    assign ctrl_wr   = trig_wr && (lbus_a == A_CTRL);
    assign start_req = (ctrl_wr && lbus_di[0]) ||
                       (trig_wr && !key_hit && din_hit && mode_q[1] &&
                        (din_off[15:1] == 15'(DIN_N - 1)));

    always_comb begin
        state_d   = state_q;
        dly_d     = dly_q << 1;
        kbusy_d   = kbusy_q;
        done_d    = done_q;
        ovr_d     = ovr_q;
        lat_d     = lat_q;
        mode_d    = mode_q;
        key_d     = key_q;
        din_d     = din_q;
        dout_d    = dout_q;
        krdy_d    = ctrl_wr && lbus_di[1];
        srst_d    = ctrl_wr && lbus_di[2];
        rst_act_d = srst_q;

        if (trig_wr) begin
            if (key_hit) begin
                for (int i = 0; i < KEY_N; i++)
                    if (key_off[15:1] == 15'(i)) key_d[KEY_W-1-16*i -: 16] = lbus_di;
            end else if (din_hit) begin
                for (int i = 0; i < DIN_N; i++)
                    if (din_off[15:1] == 15'(i)) din_d[DIN_W-1-16*i -: 16] = lbus_di;
            end
            if (lbus_a == A_MODE) mode_d = lbus_di[1:0];
        end
        if (ctrl_wr && lbus_di[4]) ovr_d = 1'b0;

        case (state_q)
            S_WAIT_DRDY: if (dly_q[TRIG_DLY-1]) state_d = S_RUN;
            S_RUN: begin
                lat_d = (lat_q == 16'hFFFF) ? lat_q : lat_q + 16'd1;
                if (blk_dvld) begin
                    dout_d  = blk_dout;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: ;
        endcase

        if (start_req) begin
            if (!dbusy) begin
                state_d  = S_WAIT_DRDY;
                done_d   = 1'b0;
                lat_d    = 16'h0000;
                dly_d    = '0;
                dly_d[0] = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end

        // A key load that coincides with kvld must leave the key marked busy.
        if (blk_kvld) kbusy_d = 1'b0;
        if (krdy_q)   kbusy_d = 1'b1;

        if (srst_d) begin
            state_d = S_IDLE;
            dly_d   = '0;
            kbusy_d = 1'b0;
            done_d  = 1'b0;
            ovr_d   = 1'b0;
            lat_d   = 16'h0000;
        end
    end

    always_comb begin
        rdata = 16'h0000;
        if (lbus_a == A_CTRL)      rdata = status;
        else if (lbus_a == A_LAT)  rdata = lat_q;
        else if (lbus_a == A_MODE) rdata = {14'b0, mode_q};
        else if (lbus_a == A_ID)   rdata = ID_CODE;
        else if (dout_hit) begin
            for (int i = 0; i < DOUT_N; i++)
                if (dout_off[15:1] == 15'(i)) rdata = dout_q[DOUT_W-1-16*i -: 16];
        end
`ifdef LBUS_READBACK_EN
        else if (key_hit) begin
            for (int i = 0; i < KEY_N; i++)
                if (key_off[15:1] == 15'(i)) rdata = key_q[KEY_W-1-16*i -: 16];
        end else if (din_hit) begin
            for (int i = 0; i < DIN_N; i++)
                if (din_off[15:1] == 15'(i)) rdata = din_q[DIN_W-1-16*i -: 16];
        end
`endif
        do_d = lbus_rd ? do_q : rdata;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= S_IDLE;
            wr_sync_q <= '0;
            dly_q     <= '0;
            krdy_q    <= 1'b0;
            srst_q    <= 1'b0;
            rst_act_q <= 1'b0;
            kbusy_q   <= 1'b0;
            done_q    <= 1'b0;
            ovr_q     <= 1'b0;
            lat_q     <= '0;
            do_q      <= '0;
            mode_q    <= '0;
            key_q     <= '0;
            din_q     <= '0;
            dout_q    <= '0;
        end else begin
            state_q   <= state_d;
            wr_sync_q <= wr_sync_d;
            dly_q     <= dly_d;
            krdy_q    <= krdy_d;
            srst_q    <= srst_d;
            rst_act_q <= rst_act_d;
            kbusy_q   <= kbusy_d;
            done_q    <= done_d;
            ovr_q     <= ovr_d;
            lat_q     <= lat_d;
            do_q      <= do_d;
            mode_q    <= mode_d;
            key_q     <= key_d;
            din_q     <= din_d;
            dout_q    <= dout_d;
        end
    end

    assign lbus_do    = do_q;
    assign blk_kin    = key_q;
    assign blk_din    = din_q;
    assign blk_krdy   = krdy_q;
    assign blk_drdy   = dly_q[TRIG_DLY-1];
    assign blk_encdec = mode_q[0];
    assign blk_en     = 1'b1;
    assign blk_rstn   = ~srst_q;
endmodule

// File: tb/tb_lbus_if_param.sv
// Bench for lbus_if_param: register table, directed start/overrun/soft-reset
// sequences, and randomized bus traffic against a word-array reference model.
module tb_lbus_if_param;
    localparam int          TRIG_DLY  = 3;
    localparam int          DV_LAT    = 20;
    localparam int          KV_LAT    = 10;
    localparam logic [15:0] KEY_BASE  = 16'h0100;
    localparam logic [15:0] DIN_BASE  = 16'h0140;
    localparam logic [15:0] DOUT_BASE = 16'h0180;
`ifdef LBUS_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic [15:0]  lbus_a = '0, lbus_di = '0, lbus_do;
    logic         lbus_wr = 1'b0, lbus_rd = 1'b0;
    logic [127:0] blk_kin, blk_dout = '0;
    logic [511:0] blk_din;
    logic         blk_krdy, blk_drdy, blk_encdec, blk_en, blk_rstn;
    logic         blk_kvld = 1'b0, blk_dvld = 1'b0;

    lbus_if_param dut (
        .clk(clk), .rstn(rstn), .lbus_a(lbus_a), .lbus_di(lbus_di), .lbus_wr(lbus_wr),
        .lbus_rd(lbus_rd), .lbus_do(lbus_do), .blk_kin(blk_kin), .blk_din(blk_din),
        .blk_dout(blk_dout), .blk_krdy(blk_krdy), .blk_drdy(blk_drdy), .blk_kvld(blk_kvld),
        .blk_dvld(blk_dvld), .blk_encdec(blk_encdec), .blk_en(blk_en), .blk_rstn(blk_rstn)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;
    int cyc = 0, wr_cyc = 0;
    int drdy_cnt = 0, krdy_cnt = 0, rstl_cnt = 0, drdy_last = 0;
    int dv_cnt = 0, kv_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Core model and pulse monitors: dvld DV_LAT cycles after drdy, kvld KV_LAT after krdy.
    always @(negedge clk) begin
        blk_dvld <= 1'b0;
        blk_kvld <= 1'b0;
        if (dv_cnt == 1) blk_dvld <= 1'b1;
        if (kv_cnt == 1) blk_kvld <= 1'b1;
        if (dv_cnt != 0) dv_cnt <= dv_cnt - 1;
        if (kv_cnt != 0) kv_cnt <= kv_cnt - 1;
        if (blk_drdy) begin dv_cnt <= DV_LAT; drdy_cnt <= drdy_cnt + 1; drdy_last <= cyc; end
        if (blk_krdy) begin kv_cnt <= KV_LAT; krdy_cnt <= krdy_cnt + 1; end
        if (!blk_rstn) rstl_cnt <= rstl_cnt + 1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Reference model state
    logic [15:0] m_key [8];
    logic [15:0] m_din [32];
    logic [15:0] m_dout[8];
    logic        m_encdec = 1'b0, m_auto = 1'b0, m_done = 1'b0, m_ovr = 1'b0;
    logic [15:0] m_lat = '0;

    task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic chkw(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic bus_wr(input logic [15:0] a, input logic [15:0] d, input int hold);
        @(posedge clk); #1;
        lbus_a = a; lbus_di = d; lbus_wr = 1'b1; wr_cyc = cyc;
        repeat (hold) @(posedge clk);
        #1 lbus_wr = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    task automatic bus_rd(input logic [15:0] a, output logic [15:0] d);
        @(posedge clk); #1;
        lbus_a = a; lbus_rd = 1'b0;
        @(posedge clk);
        @(negedge clk);
        d = lbus_do;
    endtask

    function automatic logic [511:0] pack_din();
        logic [511:0] r = '0;
        for (int i = 0; i < 32; i++) r = {r[495:0], m_din[i]};
        return r;
    endfunction

    function automatic logic [127:0] pack_key();
        logic [127:0] r = '0;
        for (int i = 0; i < 8; i++) r = {r[111:0], m_key[i]};
        return r;
    endfunction

    function automatic bit in_win(input logic [15:0] a, input logic [15:0] base, input int n);
        return (a >= base) && ({16'b0, a} < {16'b0, base} + 32'(2 * n)) && !a[0];
    endfunction

    task automatic m_write(input logic [15:0] a, input logic [15:0] d);
        if (in_win(a, KEY_BASE, 8))      m_key[(a - KEY_BASE) >> 1] = d;
        else if (in_win(a, DIN_BASE, 32)) m_din[(a - DIN_BASE) >> 1] = d;
        if (a == 16'h000C) begin m_encdec = d[0]; m_auto = d[1]; end
    endtask

    function automatic logic [15:0] exp_rd(input logic [15:0] a);
        if (a == 16'h0002) return {11'b0, m_ovr, m_done, 3'b000};
        if (a == 16'h0004) return m_lat;
        if (a == 16'h000C) return {14'b0, m_auto, m_encdec};
        if (a == 16'hFFFC) return 16'h4702;
        if (in_win(a, DOUT_BASE, 8)) return m_dout[(a - DOUT_BASE) >> 1];
        if (RB && in_win(a, KEY_BASE, 8)) return m_key[(a - KEY_BASE) >> 1];
        if (RB && in_win(a, DIN_BASE, 32)) return m_din[(a - DIN_BASE) >> 1];
        return 16'h0000;
    endfunction

    typedef struct {
        bit          wr;
        logic [15:0] a;
        logic [15:0] d;
        logic [15:0] exp;
    } vec_t;
    vec_t tbl[24];
    int   nv = 0;

    task automatic add(input bit w, input logic [15:0] a, input logic [15:0] d, input logic [15:0] e);
        tbl[nv] = '{w, a, d, e};
        nv++;
    endtask

    initial begin
        logic [15:0]  rd, a, d;
        logic [127:0] v2, v3;
        int           c0;

        add(0, 16'hFFFC, 16'h0, 16'h4702);
        add(0, 16'h0002, 16'h0, 16'h0000);
        add(0, 16'h0004, 16'h0, 16'h0000);
        add(0, 16'h000C, 16'h0, 16'h0000);
        add(0, 16'h0180, 16'h0, 16'h0000);
        add(0, 16'h1234, 16'h0, 16'h0000);
        for (int i = 0; i < 8; i++) add(1, KEY_BASE + 16'(2 * i), 16'(i + 1), 16'h0);
        add(1, 16'h0110, 16'hDEAD, 16'h0);
        add(1, 16'h00FE, 16'hBEEF, 16'h0);
        add(1, 16'h000C, 16'h0001, 16'h0);
        add(0, 16'h000C, 16'h0, 16'h0001);
        add(0, 16'h0100, 16'h0, RB ? 16'h0001 : 16'h0000);
        add(0, 16'h010E, 16'h0, RB ? 16'h0008 : 16'h0000);
        add(0, 16'h0110, 16'h0, 16'h0000);

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk16("rst lbus_do", lbus_do, 16'h0000);
        chk16("rst blk_rstn", {15'b0, blk_rstn}, 16'h0001);
        chk16("rst blk_en", {15'b0, blk_en}, 16'h0001);
        chk16("rst drdy/krdy/encdec", {13'b0, blk_drdy, blk_krdy, blk_encdec}, 16'h0000);
        chkw("rst kin", 512'(blk_kin), 512'h0);
        rstn = 1'b1;

        for (int i = 0; i < nv; i++) begin
            if (tbl[i].wr) bus_wr(tbl[i].a, tbl[i].d, 4);
            else begin
                bus_rd(tbl[i].a, rd);
                chk16($sformatf("tbl[%0d] rd %h", i, tbl[i].a), rd, tbl[i].exp);
            end
        end
        chkw("kin after key writes", 512'(blk_kin), 512'h0001_0002_0003_0004_0005_0006_0007_0008);
        chk16("encdec after mode=1", {15'b0, blk_encdec}, 16'h0001);
        for (int i = 0; i < 8; i++) m_key[i] = 16'(i + 1);

        // Read data holds while lbus_rd is high
        bus_rd(16'hFFFC, rd);
        lbus_rd = 1'b1; lbus_a = 16'h0004;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk16("rd hold", lbus_do, 16'h4702);
        lbus_rd = 1'b0;

        // Key load pulse and kbusy
        c0 = krdy_cnt;
        bus_wr(16'h0002, 16'h0002, 4);
        bus_rd(16'h0002, rd);
        chk16("status kbusy", rd, 16'h0002);
        chk16("krdy pulses", 16'(krdy_cnt - c0), 16'd1);
        repeat (15) @(posedge clk);
        bus_rd(16'h0002, rd);
        chk16("status after kvld", rd, 16'h0000);

        // Autostart on the last data-in word
        bus_wr(16'h000C, 16'h0002, 4);
        chk16("encdec after mode=2", {15'b0, blk_encdec}, 16'h0000);
        v2 = {$urandom, $urandom, $urandom, $urandom};
        blk_dout = v2;
        c0 = drdy_cnt;
        for (int i = 0; i < 32; i++) begin
            m_din[i] = 16'($urandom_range(0, 65535));
            bus_wr(DIN_BASE + 16'(2 * i), m_din[i], 4);
            if (i == 30) chk16("no drdy before last word", 16'(drdy_cnt - c0), 16'd0);
        end
        chk16("autostart drdy count", 16'(drdy_cnt - c0), 16'd1);
        chk16("autostart drdy delay", 16'(drdy_last - wr_cyc), 16'(2 + TRIG_DLY));
        chkw("blk_din", blk_din, pack_din());
        repeat (25) @(posedge clk);
        bus_rd(16'h0002, rd);
        chk16("status done", rd, 16'h0008);
        bus_rd(16'h0004, rd);
        chk16("latency", rd, 16'd20);
        for (int i = 0; i < 8; i++) begin
            m_dout[i] = v2[127-16*i -: 16];
            bus_rd(DOUT_BASE + 16'(2 * i), rd);
            chk16($sformatf("dout word %0d", i), rd, m_dout[i]);
        end

        // Overrun: second start while busy is dropped
        c0 = drdy_cnt;
        bus_wr(16'h0002, 16'h0001, 4);
        bus_wr(16'h0002, 16'h0001, 4);
        bus_rd(16'h0002, rd);
        chk16("status busy+ovr", rd, 16'h0011);
        repeat (20) @(posedge clk);
        chk16("ovr drdy count", 16'(drdy_cnt - c0), 16'd1);
        bus_rd(16'h0002, rd);
        chk16("status done+ovr", rd, 16'h0018);
        bus_wr(16'h0002, 16'h0010, 4);
        bus_rd(16'h0002, rd);
        chk16("status ovr cleared", rd, 16'h0008);

        // Soft reset during RUN
        v3 = {$urandom, $urandom, $urandom, $urandom};
        blk_dout = v3;
        c0 = rstl_cnt;
        bus_wr(16'h0002, 16'h0001, 4);
        bus_wr(16'h0002, 16'h0004, 4);
        chk16("soft rst low cycles", 16'(rstl_cnt - c0), 16'd1);
        bus_rd(16'h0002, rd);
        chk16("status after soft rst", rd, 16'h0000);
        repeat (20) @(posedge clk);
        bus_rd(16'h0002, rd);
        chk16("late dvld ignored", rd, 16'h0000);
        bus_rd(16'h0004, rd);
        chk16("lat cleared", rd, 16'h0000);
        bus_rd(DOUT_BASE, rd);
        chk16("dout kept", rd, v2[127:112]);

        // Long write strobe gives one write
        c0 = drdy_cnt;
        bus_wr(16'h0002, 16'h0001, 10);
        repeat (20) @(posedge clk);
        chk16("held wr drdy count", 16'(drdy_cnt - c0), 16'd1);
        bus_rd(16'h0002, rd);
        chk16("held wr done", rd, 16'h0008);
        for (int i = 0; i < 8; i++) m_dout[i] = v3[127-16*i -: 16];
        m_done = 1'b1; m_ovr = 1'b0; m_lat = 16'd20;

        // Randomized traffic against the model
        bus_wr(16'h000C, 16'h0000, 4);
        m_write(16'h000C, 16'h0000);
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 1) == 0) begin
                d = 16'($urandom_range(0, 65535));
                case ($urandom_range(0, 9))
                    0, 1, 2, 3: a = KEY_BASE + 16'(2 * $urandom_range(0, 7));
                    4, 5, 6, 7: a = DIN_BASE + 16'(2 * $urandom_range(0, 31));
                    8:          begin a = 16'h000C; d = d & 16'h0001; end
                    default: begin
                        a = 16'($urandom_range(0, 65535));
                        if (a == 16'h0002 || a == 16'h000C) a = 16'h0006;
                    end
                endcase
                bus_wr(a, d, 4);
                m_write(a, d);
            end else begin
                case ($urandom_range(0, 7))
                    0: a = KEY_BASE + 16'(2 * $urandom_range(0, 7));
                    1: a = DIN_BASE + 16'(2 * $urandom_range(0, 31));
                    2: a = DOUT_BASE + 16'(2 * $urandom_range(0, 7));
                    3: a = 16'h0002;
                    4: a = 16'h0004;
                    5: a = 16'h000C;
                    6: a = 16'hFFFC;
                    default: a = 16'($urandom_range(0, 65535));
                endcase
                bus_rd(a, rd);
                chk16($sformatf("rand rd %h", a), rd, exp_rd(a));
            end
        end
        chkw("rand kin", 512'(blk_kin), 512'(pack_key()));
        chkw("rand din", blk_din, pack_din());
        chk16("rand encdec", {15'b0, blk_encdec}, {15'b0, m_encdec});

        // Asynchronous reset while waiting for drdy
        c0 = drdy_cnt;
        @(posedge clk); #1;
        lbus_a = 16'h0002; lbus_di = 16'h0001; lbus_wr = 1'b1;
        repeat (4) @(posedge clk);
        #2 rstn = 1'b0;
        #1;
        chk16("arst drdy/krdy", {14'b0, blk_drdy, blk_krdy}, 16'h0000);
        chk16("arst lbus_do", lbus_do, 16'h0000);
        chkw("arst kin", 512'(blk_kin), 512'h0);
        lbus_wr = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        repeat (10) @(posedge clk);
        chk16("arst no drdy", 16'(drdy_cnt - c0), 16'd0);
        bus_rd(16'h0002, rd);
        chk16("arst status", rd, 16'h0000);
        bus_rd(16'h000C, rd);
        chk16("arst mode", rd, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
